// File: rtl/reg_bank_pkg.sv
// -----------------------------------------------------------------------------
// reg_bank_pkg
// Shared datapath sizing for the general register file. The decode and
// writeback stages import these so that operand/result widths and register
// addresses stay consistent with the register bank.
// -----------------------------------------------------------------------------
package reg_bank_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 2;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage : reg_bank_pkg

// File: rtl/reg_bank_read_port.sv
// -----------------------------------------------------------------------------
// reg_bank_read_port
// One asynchronous read port of the register bank: an N_REGS:1 mux of
// DATA_W-bit words. No clock is involved; the output follows the address and
// the register contents combinationally.
//
// Ports
//   regs_i  in   N_REGS x DATA_W   current register contents
//   addr_i  in   ADDR_W            read address
//   data_o  out  DATA_W            selected register
// -----------------------------------------------------------------------------
module reg_bank_read_port
    import reg_bank_pkg::*;
#(
    parameter int DATA_W = reg_bank_pkg::DATA_W,
    parameter int ADDR_W = reg_bank_pkg::ADDR_W,
    parameter int N_REGS = 2 ** ADDR_W
) (
    input  logic [N_REGS-1:0][DATA_W-1:0] regs_i,
    input  logic [ADDR_W-1:0]             addr_i,
    output logic [DATA_W-1:0]             data_o
);

    // Every address is valid (N_REGS == 2**ADDR_W), so no out-of-range guard.
    // An unknown address only affects this output; storage is untouched.
    always_comb begin
        data_o = regs_i[addr_i];
    end

endmodule : reg_bank_read_port

// File: rtl/reg_bank.sv
// -----------------------------------------------------------------------------
// reg_bank
// 4 x 32-bit general register file: one synchronous write port (writeback
// result) and two independent asynchronous read ports (source operands).
// Register 0 is an ordinary writable register. There is no write-to-read
// bypass: a read of the register being written shows the old value until the
// clock edge and the new value right after it.
//
// Ports (positional order is fixed for existing instantiations)
//   clk       in   1       system clock, rising-edge
//   e_l       in   1       write enable, active-high
//   reg_e     in   ADDR_W  write address
//   fnt1      in   ADDR_W  read address, port 1
//   fnt2      in   ADDR_W  read address, port 2
//   dado      in   DATA_W  write data
//   dado_l_1  out  DATA_W  read data, port 1
//   dado_l_2  out  DATA_W  read data, port 2
//   rst_n     in   1       asynchronous active-low reset, clears all registers
// -----------------------------------------------------------------------------
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int DATA_W = reg_bank_pkg::DATA_W,
    parameter int ADDR_W = reg_bank_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              e_l,
    input  logic [ADDR_W-1:0] reg_e,
    input  logic [ADDR_W-1:0] fnt1,
    input  logic [ADDR_W-1:0] fnt2,
    input  logic [DATA_W-1:0] dado,
    output logic [DATA_W-1:0] dado_l_1,
    output logic [DATA_W-1:0] dado_l_2,
    input  logic              rst_n
);

    localparam int N_REGS = 2 ** ADDR_W;

    logic [N_REGS-1:0][DATA_W-1:0] regs_q;
    logic [N_REGS-1:0][DATA_W-1:0] regs_d;
    logic [N_REGS-1:0]             wr_sel;

    // One-hot write decode; all-zero when the write port is idle.
    always_comb begin
        wr_sel = '0;
        if (e_l) begin
            wr_sel[reg_e] = 1'b1;
        end
    end

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < N_REGS; i++) begin
            if (wr_sel[i]) begin
                regs_d[i] = dado;
            end
        end
    end

    // Reset is asynchronous, so it clears storage immediately and wins over
    // any write presented at the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    reg_bank_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .N_REGS (N_REGS)
    ) u_rd_port_1 (
        .regs_i (regs_q),
        .addr_i (fnt1),
        .data_o (dado_l_1)
    );

    reg_bank_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .N_REGS (N_REGS)
    ) u_rd_port_2 (
        .regs_i (regs_q),
        .addr_i (fnt2),
        .data_o (dado_l_2)
    );

endmodule : reg_bank

// File: tb/tb_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_reg_bank
// Self-checking bench for reg_bank. A plain array model holds what each
// register must contain; a compare process checks both read ports against it
// shortly after every clock edge, and directed sequences pin the model with
// literal expected values.
// -----------------------------------------------------------------------------
module tb_reg_bank;

    localparam int DW = 32;
    localparam int AW = 2;
    localparam int NR = 4;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          e_l   = 1'b0;
    logic [AW-1:0] reg_e = '0;
    logic [AW-1:0] fnt1  = '0;
    logic [AW-1:0] fnt2  = '0;
    logic [DW-1:0] dado  = '0;
    logic [DW-1:0] dado_l_1;
    logic [DW-1:0] dado_l_2;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] model [NR] = '{default: '0};

    reg_bank dut (
        .clk      (clk),
        .e_l      (e_l),
        .reg_e    (reg_e),
        .fnt1     (fnt1),
        .fnt2     (fnt2),
        .dado     (dado),
        .dado_l_1 (dado_l_1),
        .dado_l_2 (dado_l_2),
        .rst_n    (rst_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%08h expected=%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: reset empties every register at once; otherwise an
    // enabled rising edge stores the write data at the write address.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) model[i] = '0;
        end else if (e_l) begin
            model[reg_e] = dado;
        end
    end

    // Compare process: just after each clock edge both ports must show the
    // model's content of the addressed register.
    always @(clk) begin
        #1;
        chk("port1_vs_model", dado_l_1, model[fnt1]);
        chk("port2_vs_model", dado_l_2, model[fnt2]);
    end

    task automatic write_reg(input int a, input logic [DW-1:0] d);
        @(negedge clk);
        e_l   = 1'b1;
        reg_e = AW'(a);
        dado  = d;
    endtask

    initial begin
        // Reset with arbitrary read addresses.
        #1 rst_n = 1'b0;
        fnt1 = 2'd2;
        fnt2 = 2'd1;
        repeat (2) @(negedge clk);
        for (int a = 0; a < NR; a++) begin
            fnt1 = AW'(a);
            fnt2 = AW'(NR - 1 - a);
            #1;
            chk("reset_p1", dado_l_1, 32'h0);
            chk("reset_p2", dado_l_2, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int a = 0; a < NR; a++) begin
            fnt1 = AW'(a);
            #1 chk("after_reset", dado_l_1, 32'h0);
        end

        // Register 0 is writable.
        write_reg(0, 32'd256);
        @(negedge clk);
        e_l  = 1'b0;
        fnt1 = 2'd0;
        #1 chk("reg0_write", dado_l_1, 32'd256);

        // Second register via port 2.
        write_reg(1, 32'd128);
        @(negedge clk);
        e_l  = 1'b0;
        fnt2 = 2'd1;
        fnt1 = 2'd0;
        #1;
        chk("reg1_port2", dado_l_2, 32'd128);
        chk("reg0_kept", dado_l_1, 32'd256);

        // Write disabled across several edges.
        @(negedge clk);
        e_l   = 1'b0;
        reg_e = 2'd2;
        dado  = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        fnt1 = 2'd2;
        #1 chk("write_disabled", dado_l_1, 32'h0);

        // Read during write: old value before the edge, new value after.
        @(negedge clk);
        fnt1  = 2'd3;
        fnt2  = 2'd3;
        e_l   = 1'b1;
        reg_e = 2'd3;
        dado  = 32'h12345678;
        #1;
        chk("rdw_before_p1", dado_l_1, 32'h0);
        chk("rdw_before_p2", dado_l_2, 32'h0);
        @(posedge clk);
        #1;
        chk("rdw_after_p1", dado_l_1, 32'h12345678);
        chk("rdw_after_p2", dado_l_2, 32'h12345678);

        // Fill 1..4 then reset between clock edges.
        for (int a = 0; a < NR; a++) write_reg(a, DW'(a + 1));
        @(negedge clk);
        e_l  = 1'b0;
        fnt1 = 2'd2;
        fnt2 = 2'd3;
        #1;
        chk("fill_r2", dado_l_1, 32'd3);
        chk("fill_r3", dado_l_2, 32'd4);
        #1 rst_n = 1'b0;
        fnt1 = 2'd0;
        fnt2 = 2'd1;
        #1;
        chk("async_rst_r0", dado_l_1, 32'h0);
        chk("async_rst_r1", dado_l_2, 32'h0);
        fnt1 = 2'd2;
        fnt2 = 2'd3;
        #1;
        chk("async_rst_r2", dado_l_1, 32'h0);
        chk("async_rst_r3", dado_l_2, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic with occasional reset pulses, checked by the
        // compare process against the model.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rst_n = ($urandom_range(63) != 0);
            e_l   = $urandom_range(1);
            reg_e = AW'($urandom_range(NR - 1));
            fnt1  = AW'($urandom_range(NR - 1));
            fnt2  = ($urandom_range(3) == 0) ? fnt1 : AW'($urandom_range(NR - 1));
            dado  = $urandom();
        end

        @(negedge clk);
        rst_n = 1'b1;
        e_l   = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reg_bank
